// File: rtl/phy_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : phy_rx_deframer
// Brief    : Strips STP/SDP..END/EDB framing from the PHY symbol stream and
//            emits TLP/DLLP payload bytes with SOP/EOP/ABORT and error stats.
// Revision : 1.0 - initial release
// ============================================================================
module phy_rx_deframer #(
    parameter int         MAX_TLP_BYTES = 64,
    parameter int         DLLP_BYTES    = 6,
    parameter logic [7:0] STP           = 8'hFB,
    parameter logic [7:0] SDP           = 8'h5C,
    parameter logic [7:0] END           = 8'hFD,
    parameter logic [7:0] EDB           = 8'hFE
) (
    input  logic        CLK,
    input  logic        RESET_L,
    input  logic [7:0]  DATA_IN,
    input  logic [1:0]  CONTROL_IN,
    output logic [7:0]  PKT_DATA,
    output logic        PKT_VALID,
    output logic        PKT_SOP,
    output logic        PKT_EOP,
    output logic        PKT_ABORT,
    output logic        PKT_IS_DLLP,
    output logic        ERROR_DLL,
    output logic [15:0] PKT_COUNT,
    output logic [7:0]  ERR_COUNT
);

    // Counter holds up to MAX_TLP_BYTES+1 so the overflow byte is detectable.
    localparam int c_cnt_w = $clog2(MAX_TLP_BYTES + 2);
    localparam logic [c_cnt_w-1:0] c_max_tlp  = c_cnt_w'(MAX_TLP_BYTES);
    localparam logic [c_cnt_w-1:0] c_dllp_len = c_cnt_w'(DLLP_BYTES);
    localparam logic [1:0] c_cls_data  = 2'b00;
    localparam logic [1:0] c_cls_frame = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IN_TLP  = 2'd1,
        ST_IN_DLLP = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_count;
    logic [7:0]           r_hold;
    logic                 r_hold_first;
    logic                 r_is_dllp;

    logic                 w_is_data;
    logic                 w_is_stp;
    logic                 w_is_sdp;
    logic                 w_is_end;
    logic                 w_is_edb;
    logic                 w_held;
    logic [c_cnt_w-1:0]   w_cnt_next;
    logic [c_cnt_w-1:0]   w_limit;

    logic                 w_emit;
    logic                 w_eop;
    logic                 w_abort;
    logic                 w_err;
    logic                 w_good;
    logic                 w_capture;
    logic                 w_open;
    state_t               w_next;

    assign w_is_data  = (CONTROL_IN == c_cls_data);
    assign w_is_stp   = (CONTROL_IN == c_cls_frame) && (DATA_IN == STP);
    assign w_is_sdp   = (CONTROL_IN == c_cls_frame) && (DATA_IN == SDP);
    assign w_is_end   = (CONTROL_IN == c_cls_frame) && (DATA_IN == END);
    assign w_is_edb   = (CONTROL_IN == c_cls_frame) && (DATA_IN == EDB);
    assign w_held     = (r_count != '0);
    assign w_cnt_next = r_count + 1'b1;
    assign w_limit    = (r_state == ST_IN_DLLP) ? c_dllp_len : c_max_tlp;

    always_comb begin
        w_emit    = 1'b0;
        w_eop     = 1'b0;
        w_abort   = 1'b0;
        w_err     = 1'b0;
        w_good    = 1'b0;
        w_capture = 1'b0;
        w_open    = 1'b0;
        w_next    = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_is_stp || w_is_sdp) begin
                    w_open = 1'b1;
                end else if (w_is_data || CONTROL_IN == c_cls_frame) begin
                    w_err = 1'b1;
                end
            end
            ST_IN_TLP, ST_IN_DLLP: begin
                if (w_is_data) begin
                    w_emit = w_held;
                    if (w_cnt_next > w_limit) begin
                        w_err   = 1'b1;
                        w_eop   = 1'b1;
                        w_abort = 1'b1;
                        w_next  = ST_DISCARD;
                    end else begin
                        w_capture = 1'b1;
                    end
                end else if (w_is_stp || w_is_sdp) begin
                    w_err   = 1'b1;
                    w_emit  = w_held;
                    w_eop   = 1'b1;
                    w_abort = 1'b1;
                    w_open  = 1'b1;
                end else if (w_is_end) begin
                    w_next = ST_IDLE;
                    if (!w_held) begin
                        w_err = 1'b1;
                    end else if (r_state == ST_IN_DLLP && r_count != c_dllp_len) begin
                        w_err   = 1'b1;
                        w_emit  = 1'b1;
                        w_eop   = 1'b1;
                        w_abort = 1'b1;
                    end else begin
                        w_emit = 1'b1;
                        w_eop  = 1'b1;
                        w_good = 1'b1;
                    end
                end else if (w_is_edb) begin
                    // Nullified TLP is legal; EDB closing a DLLP is not.
                    w_err   = (r_state == ST_IN_DLLP);
                    w_emit  = w_held;
                    w_eop   = 1'b1;
                    w_abort = 1'b1;
                    w_next  = ST_IDLE;
                end else begin
                    w_err   = 1'b1;
                    w_emit  = w_held;
                    w_eop   = 1'b1;
                    w_abort = 1'b1;
                    w_next  = ST_IDLE;
                end
            end
            default: begin
                if (w_is_stp || w_is_sdp) begin
                    w_open = 1'b1;
                end else if (w_is_end || w_is_edb) begin
                    w_next = ST_IDLE;
                end
            end
        endcase
        if (w_open) begin
            w_next = w_is_sdp ? ST_IN_DLLP : ST_IN_TLP;
        end
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_hold       <= 8'h00;
            r_hold_first <= 1'b0;
            r_is_dllp    <= 1'b0;
            PKT_DATA     <= 8'h00;
            PKT_VALID    <= 1'b0;
            PKT_SOP      <= 1'b0;
            PKT_EOP      <= 1'b0;
            PKT_ABORT    <= 1'b0;
            PKT_IS_DLLP  <= 1'b0;
            ERROR_DLL    <= 1'b0;
            PKT_COUNT    <= 16'h0000;
            ERR_COUNT    <= 8'h00;
        end else begin
            r_state   <= w_next;
            PKT_VALID <= w_emit;
            PKT_SOP   <= w_emit & r_hold_first;
            PKT_EOP   <= w_emit & w_eop;
            PKT_ABORT <= w_emit & w_abort;
            ERROR_DLL <= w_err;
            if (w_emit) begin
                PKT_DATA    <= r_hold;
                PKT_IS_DLLP <= r_is_dllp;
            end
            if (w_capture) begin
                r_hold       <= DATA_IN;
                r_hold_first <= (r_count == '0);
                r_count      <= w_cnt_next;
            end else if (w_open || (w_next != ST_IN_TLP && w_next != ST_IN_DLLP)) begin
                r_count <= '0;
            end
            if (w_open) begin
                r_is_dllp <= w_is_sdp;
            end
            if (w_good) begin
                PKT_COUNT <= PKT_COUNT + 16'd1;
            end
            if (w_err && ERR_COUNT != 8'hFF) begin
                ERR_COUNT <= ERR_COUNT + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_phy_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tb_phy_rx_deframer
// Brief    : Directed and randomized frame-level checks of phy_rx_deframer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phy_rx_deframer;

    localparam int         MAX  = 64;
    localparam int         DLEN = 6;
    localparam logic [7:0] STP  = 8'hFB;
    localparam logic [7:0] SDP  = 8'h5C;
    localparam logic [7:0] ENDS = 8'hFD;
    localparam logic [7:0] EDB  = 8'hFE;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic       abort;
        logic       dllp;
    } rec_t;

    logic        CLK;
    logic        RESET_L;
    logic [7:0]  DATA_IN;
    logic [1:0]  CONTROL_IN;
    logic [7:0]  PKT_DATA;
    logic        PKT_VALID;
    logic        PKT_SOP;
    logic        PKT_EOP;
    logic        PKT_ABORT;
    logic        PKT_IS_DLLP;
    logic        ERROR_DLL;
    logic [15:0] PKT_COUNT;
    logic [7:0]  ERR_COUNT;

    phy_rx_deframer #(
        .MAX_TLP_BYTES(MAX), .DLLP_BYTES(DLEN),
        .STP(STP), .SDP(SDP), .END(ENDS), .EDB(EDB)
    ) dut (
        .CLK(CLK), .RESET_L(RESET_L), .DATA_IN(DATA_IN), .CONTROL_IN(CONTROL_IN),
        .PKT_DATA(PKT_DATA), .PKT_VALID(PKT_VALID), .PKT_SOP(PKT_SOP),
        .PKT_EOP(PKT_EOP), .PKT_ABORT(PKT_ABORT), .PKT_IS_DLLP(PKT_IS_DLLP),
        .ERROR_DLL(ERROR_DLL), .PKT_COUNT(PKT_COUNT), .ERR_COUNT(ERR_COUNT)
    );

    rec_t exp_q[$];
    rec_t got_q[$];
    int   got_cyc[$];
    int   cyc = 0;
    int   err_pulses = 0;
    int   last_err_cyc = -1;
    int   exp_pulses = 0;
    int   exp_pkt = 0;
    int   exp_errcnt = 0;
    int   checks = 0;
    int   failures = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (PKT_VALID) begin
            got_q.push_back({PKT_DATA, PKT_SOP, PKT_EOP, PKT_ABORT, PKT_IS_DLLP});
            got_cyc.push_back(cyc);
        end
        if (ERROR_DLL) begin
            err_pulses++;
            last_err_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic sym(input logic [1:0] c, input logic [7:0] d);
        @(posedge CLK);
        #1;
        CONTROL_IN = c;
        DATA_IN    = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) sym(((i % 2) == 0) ? 2'b10 : 2'b11, 8'hBC);
    endtask

    task automatic expect_err();
        exp_pulses++;
        exp_errcnt = (exp_errcnt < 255) ? exp_errcnt + 1 : 255;
    endtask

    // n payload bytes sent; the first 'keep' reach the output, last kept one carries EOP.
    task automatic payload(input int n, input bit dllp, input int keep, input bit abort);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            sym(2'b00, d);
            if (i < keep)
                exp_q.push_back({d, (i == 0), (i == keep - 1),
                                 (i == keep - 1) && abort, dllp});
        end
    endtask

    task automatic check_stream(input string tag);
        int n;
        idle(3);
        chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_rec%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        chk({tag, "_errpulses"}, 32'(err_pulses), 32'(exp_pulses));
        chk({tag, "_pkt_count"}, 32'(PKT_COUNT), 32'(exp_pkt & 16'hFFFF));
        chk({tag, "_err_count"}, 32'(ERR_COUNT), 32'(exp_errcnt));
        got_q.delete();
        exp_q.delete();
        got_cyc.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_data"},  32'(PKT_DATA), 32'h0);
        chk({tag, "_valid"}, 32'(PKT_VALID), 32'h0);
        chk({tag, "_sop"},   32'(PKT_SOP), 32'h0);
        chk({tag, "_eop"},   32'(PKT_EOP), 32'h0);
        chk({tag, "_abort"}, 32'(PKT_ABORT), 32'h0);
        chk({tag, "_dllp"},  32'(PKT_IS_DLLP), 32'h0);
        chk({tag, "_err"},   32'(ERROR_DLL), 32'h0);
        chk({tag, "_pktc"},  32'(PKT_COUNT), 32'h0);
        chk({tag, "_errc"},  32'(ERR_COUNT), 32'h0);
    endtask

    task automatic rand_frame();
        int k;
        int n;
        k = $urandom_range(0, 7);
        idle($urandom_range(0, 2));
        case (k)
            0: begin
                n = $urandom_range(1, MAX);
                sym(2'b01, STP); payload(n, 1'b0, n, 1'b0); sym(2'b01, ENDS);
                exp_pkt++;
            end
            1: begin
                sym(2'b01, SDP); payload(DLEN, 1'b1, DLEN, 1'b0); sym(2'b01, ENDS);
                exp_pkt++;
            end
            2: begin
                n = $urandom_range(1, 10);
                sym(2'b01, STP); payload(n, 1'b0, n, 1'b1); sym(2'b01, EDB);
            end
            3: begin
                n = $urandom_range(1, DLEN - 1);
                sym(2'b01, SDP); payload(n, 1'b1, n, 1'b1); sym(2'b01, ENDS);
                expect_err();
            end
            4: begin
                sym(2'b00, 8'($urandom));
                expect_err();
            end
            5: begin
                n = MAX + $urandom_range(1, 3);
                sym(2'b01, STP); payload(n, 1'b0, MAX, 1'b1); sym(2'b01, ENDS);
                expect_err();
            end
            6: begin
                n = $urandom_range(1, 8);
                sym(2'b01, STP); payload(n, 1'b0, n, 1'b1); sym(2'b10, 8'hBC);
                expect_err();
            end
            default: begin
                sym(2'b01, STP); sym(2'b01, ENDS);
                expect_err();
            end
        endcase
    endtask

    initial begin
        RESET_L    = 1'b0;
        CONTROL_IN = 2'b10;
        DATA_IN    = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        check_outputs_zero("reset");
        RESET_L = 1'b1;
        idle(2);

        // Basic TLP: three bytes on consecutive cycles.
        sym(2'b01, STP);
        sym(2'b00, 8'h01); exp_q.push_back({8'h01, 1'b1, 1'b0, 1'b0, 1'b0});
        sym(2'b00, 8'h02); exp_q.push_back({8'h02, 1'b0, 1'b0, 1'b0, 1'b0});
        sym(2'b00, 8'h03); exp_q.push_back({8'h03, 1'b0, 1'b1, 1'b0, 1'b0});
        sym(2'b01, ENDS);
        exp_pkt++;
        idle(3);
        chk("tlp3_nvalid", 32'(got_cyc.size()), 32'd3);
        if (got_cyc.size() == 3)
            chk("tlp3_consecutive", 32'(got_cyc[2] - got_cyc[0]), 32'd2);
        check_stream("tlp3");

        sym(2'b01, SDP); payload(DLEN, 1'b1, DLEN, 1'b0); sym(2'b01, ENDS);
        exp_pkt++;
        check_stream("dllp_good");

        sym(2'b01, SDP); payload(DLEN - 1, 1'b1, DLEN - 1, 1'b1); sym(2'b01, ENDS);
        expect_err();
        check_stream("dllp_short");

        sym(2'b01, STP);
        sym(2'b00, 8'h10); exp_q.push_back({8'h10, 1'b1, 1'b0, 1'b0, 1'b0});
        sym(2'b00, 8'h20); exp_q.push_back({8'h20, 1'b0, 1'b1, 1'b1, 1'b0});
        sym(2'b01, EDB);
        check_stream("tlp_edb");

        // Overflow: error fires in the same cycle byte 64 leaves with EOP/ABORT.
        sym(2'b01, STP); payload(MAX + 3, 1'b0, MAX, 1'b1); sym(2'b01, ENDS);
        expect_err();
        idle(3);
        if (got_cyc.size() > 0)
            chk("ovf_err_cycle", 32'(last_err_cyc), 32'(got_cyc[got_cyc.size() - 1]));
        check_stream("tlp_ovf");

        sym(2'b00, 8'h55); expect_err();
        sym(2'b01, ENDS);  expect_err();
        sym(2'b01, STP);
        sym(2'b00, 8'hAA); exp_q.push_back({8'hAA, 1'b1, 1'b1, 1'b1, 1'b0});
        sym(2'b01, SDP);   expect_err();
        payload(DLEN, 1'b1, DLEN, 1'b0); sym(2'b01, ENDS);
        exp_pkt++;
        check_stream("idle_err_restart");

        for (int f = 0; f < 40; f++) rand_frame();
        check_stream("random");

        // Asynchronous reset in the middle of a TLP.
        sym(2'b01, STP);
        sym(2'b00, 8'h01); exp_q.push_back({8'h01, 1'b1, 1'b0, 1'b0, 1'b0});
        sym(2'b00, 8'h02);
        sym(2'b00, 8'h03);
        @(negedge CLK);
        chk("pre_reset_valid", 32'(PKT_VALID), 32'd1);
        #1;
        RESET_L = 1'b0;
        #1;
        check_outputs_zero("midreset");
        CONTROL_IN = 2'b10;
        @(posedge CLK);
        #1;
        RESET_L    = 1'b1;
        exp_pkt    = 0;
        exp_errcnt = 0;
        sym(2'b01, STP);
        sym(2'b00, 8'h77); exp_q.push_back({8'h77, 1'b1, 1'b1, 1'b0, 1'b0});
        sym(2'b01, ENDS);
        exp_pkt++;
        check_stream("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
